// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Each entry waits for its
// real outcome. On resolution the queue flags a mispredict with the corrected
// PC, emits a predictor training update and keeps saturating hit/miss counts.
module branch_resolve_queue #(
   parameter int unsigned n     = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [n-1:0]     push_PC,
   input  logic [n-1:0]     push_etiqueta,
   input  logic             push_prediction,
   input  logic [n-1:0]     push_nex_PC,
   input  logic             resolve,
   input  logic             fix_result,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic             mispredict,
   output logic [n-1:0]     correct_PC,
   output logic             update_valid,
   output logic [n-1:0]     update_PC,
   output logic             update_taken,
   output logic             resolve_err,
   output logic [n-1:0]     hit,
   output logic [n-1:0]     miss
);

   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [n-1:0]     FALL_THRU = n'(4);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

   // Entry storage, deliberately not reset
   logic [n-1:0] pc_mem   [DEPTH];
   logic [n-1:0] et_mem   [DEPTH];
   logic         pred_mem [DEPTH];
   logic [n-1:0] npc_mem  [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             mispredict_q, mispredict_d;
   logic [n-1:0]     correct_pc_q, correct_pc_d;
   logic             update_valid_q, update_valid_d;
   logic [n-1:0]     update_pc_q, update_pc_d;
   logic             update_taken_q, update_taken_d;
   logic             resolve_err_q, resolve_err_d;
   logic [n-1:0]     hit_q, hit_d;
   logic [n-1:0]     miss_q, miss_d;

   logic             res_acc_c;
   logic             push_acc_c;
   logic             mis_c;
   logic [n-1:0]     head_pc_c;
   logic [n-1:0]     head_et_c;
   logic             head_pred_c;
   logic [n-1:0]     head_npc_c;
   logic [n-1:0]     act_tgt_c;

   // Resolve the head entry against the real outcome and decide acceptance
   always_comb begin
      head_pc_c   = pc_mem[head_q];
      head_et_c   = et_mem[head_q];
      head_pred_c = pred_mem[head_q];
      head_npc_c  = npc_mem[head_q];
      res_acc_c   = resolve & ~empty_q;
      act_tgt_c   = fix_result ? (head_pc_c + head_et_c) : (head_pc_c + FALL_THRU);
      mis_c       = res_acc_c & ((head_pred_c != fix_result) | (head_npc_c != act_tgt_c));
      // A flush drops any same-cycle push; a pop frees a slot even when full
      push_acc_c  = push & (~full_q | res_acc_c) & ~mis_c;
   end

   // Next-state for pointers, occupancy, result pulses and counters
   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      correct_pc_d   = correct_pc_q;
      update_pc_d    = update_pc_q;
      update_taken_d = update_taken_q;
      hit_d          = hit_q;
      miss_d         = miss_q;
      mispredict_d   = mis_c;
      update_valid_d = res_acc_c;
      resolve_err_d  = resolve & empty_q;

      if (mis_c) begin
         // Discard every younger entry: queue becomes empty at the tail
         head_d  = tail_q;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(res_acc_c);
         tail_d  = tail_q + PTR_W'(push_acc_c);
         count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(res_acc_c);
      end

      if (res_acc_c) begin
         update_pc_d    = head_pc_c;
         update_taken_d = fix_result;
         if (mis_c) begin
            correct_pc_d = act_tgt_c;
            if (miss_q != '1) miss_d = miss_q + n'(1);
         end else begin
            if (hit_q != '1) hit_d = hit_q + n'(1);
         end
      end

      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         mispredict_q   <= 1'b0;
         correct_pc_q   <= '0;
         update_valid_q <= 1'b0;
         update_pc_q    <= '0;
         update_taken_q <= 1'b0;
         resolve_err_q  <= 1'b0;
         hit_q          <= '0;
         miss_q         <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         mispredict_q   <= mispredict_d;
         correct_pc_q   <= correct_pc_d;
         update_valid_q <= update_valid_d;
         update_pc_q    <= update_pc_d;
         update_taken_q <= update_taken_d;
         resolve_err_q  <= resolve_err_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
      end
   end

   // Entry write at the tail
   always_ff @(posedge clock) begin
      if (push_acc_c) begin
         pc_mem[tail_q]   <= push_PC;
         et_mem[tail_q]   <= push_etiqueta;
         pred_mem[tail_q] <= push_prediction;
         npc_mem[tail_q]  <= push_nex_PC;
      end
   end

   assign full         = full_q;
   assign empty        = empty_q;
   assign count        = count_q;
   assign mispredict   = mispredict_q;
   assign correct_PC   = correct_pc_q;
   assign update_valid = update_valid_q;
   assign update_PC    = update_pc_q;
   assign update_taken = update_taken_q;
   assign resolve_err  = resolve_err_q;
   assign hit          = hit_q;
   assign miss         = miss_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, placed directly downstream of the tournament/pshare predictor.
- Each cycle the predictor produces prediction and nex_PC. This block stores them with the branch PC and offset until the real outcome (fix_result) arrives.
- On resolution it compares prediction against outcome and raises a one-cycle mispredict/flush with the corrected PC.
- It also emits a training update for the predictor tables and keeps saturating hit/miss counters.

Parameters:
- n, 32, width of PC, offset and counters
- DEPTH, 8, queue entries; power of two, minimum 2
- PTR_W, 3, log2(DEPTH)

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- push  input  1  new prediction from predictor this cycle
- push_PC  input  n  branch PC
- push_etiqueta  input  n  branch offset (target = PC + etiqueta)
- push_prediction  input  1  predicted direction, 1 = taken
- push_nex_PC  input  n  predicted next PC
- resolve  input  1  outcome of the oldest in-flight branch is valid
- fix_result  input  1  actual direction, 1 = taken
- full  output  1  DEPTH entries held
- empty  output  1  zero entries held
- count  output  PTR_W+1  entries held
- mispredict  output  1  registered pulse: flush front end
- correct_PC  output  n  registered redirect PC, valid with mispredict
- update_valid  output  1  registered pulse: train predictor
- update_PC  output  n  PC of the resolved branch
- update_taken  output  1  actual direction of the resolved branch
- resolve_err  output  1  registered pulse: resolve arrived while empty
- hit  output  n  correct-prediction counter
- miss  output  n  misprediction counter

Behaviour:
- Reset (reset = 0, asynchronous): head/tail pointers = 0, count = 0, empty = 1, full = 0. mispredict, update_valid and resolve_err = 0. correct_PC, update_PC, update_taken, hit and miss = 0. Entry storage is not cleared.
- Storage: circular buffer. Each entry holds {PC, etiqueta, prediction, nex_PC}. Pointers are PTR_W bits and wrap from DEPTH-1 to 0.
- Push acceptance: an entry is written at tail when push=1 AND (full=0 OR a resolve is accepted in the same cycle) AND no flush is happening this cycle. Otherwise the push is silently dropped; the predictor is expected to honour full.
- Resolve acceptance: a resolve is accepted when resolve=1 and empty=0. It pops the head entry.
  - Resolve while empty: no pop, no counter change; resolve_err=1 for the next cycle.
- Comparison (on the registered cycle after an accepted resolve):
  - update_valid=1, update_PC=head.PC, update_taken=fix_result.
  - actual target = fix_result ? head.PC + head.etiqueta : head.PC + 4, computed modulo 2^n.
  - mispredict=1 if head.prediction != fix_result, OR if the directions match but head.nex_PC != actual target. In that case correct_PC = actual target.
  - Otherwise mispredict=0 and correct_PC holds its previous value.
- Output latency: 1 cycle from an accepted resolve to mispredict/update_valid. All pulse outputs are high for exactly one cycle.
- Flush: in the same cycle a mispredicting resolve is accepted, every younger entry is discarded. Next-state count = 0, head = tail, and any simultaneous push is dropped.
- Simultaneous push and resolve with no mispredict: count is unchanged. This is legal at full; the pushed entry takes the freed slot.
- Counters:
  - hit increments on a correct accepted resolve; miss increments on a mispredicting one.
  - Both saturate at all-ones and never wrap.
- full/empty/count are registered and reflect the state after the current edge.
- Reset asserted mid-operation clears everything immediately. The first push after reset deassertion is accepted on the next rising edge.

Test Plan:
- Reset then a single correct resolve: push PC=0x100, etiqueta=0x20, prediction=1, nex_PC=0x120; resolve with fix_result=1 -> next cycle update_valid=1, update_PC=0x100, update_taken=1, mispredict=0, hit=1, empty=1.
- Direction miss with flush: push 3 entries, the first being PC=0x200, prediction=0, nex_PC=0x204. Resolve with fix_result=1, etiqueta=0x40 -> mispredict=1, correct_PC=0x240, miss=1, count=0, and a push in the same cycle is dropped.
- Fill and overflow: push 8 entries -> full=1, count=8. A 9th push alone is dropped (count stays 8). Push and resolve in the same cycle (correct) -> count stays 8, the new entry is stored at wrapped tail=0.
- Resolve when empty: resolve=1 right after reset -> resolve_err=1 for one cycle; hit=0, miss=0, update_valid=0.
- Target mismatch: push PC=0x300, prediction=1, etiqueta=0x10, nex_PC=0x400; resolve with fix_result=1 -> mispredict=1, correct_PC=0x310.
- Async reset mid-stream: with 5 entries held, drive reset=0 between clock edges -> count=0, empty=1 and hit/miss=0 immediately, with no clock edge required.
